// File: rtl/clk_divider_prog.sv
// Programmable clock divider: square-wave clock_out plus a one-cycle tick per period.
// Latency: clock_out/tick are registered and lag the count they decode by one cycle.
// Backpressure: div_ready drops while a divisor is pending and rises at the period switch.
module clk_divider_prog #(
  parameter int WIDTH       = 28,
  parameter int DEFAULT_DIV = 50000000
) (
  input  logic             clock_in,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             clock_out,
  output logic             tick,
  output logic [WIDTH-1:0] div_act,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] div_act_q, div_act_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             clock_out_q, clock_out_d;
  logic             tick_q, tick_d;

  logic             accept;
  logic             wrap;
  logic             high_phase;
  logic [WIDTH-1:0] div_in_san;

  // A zero divisor would make the period meaningless, so it is stored as 1.
  assign div_in_san = (div_in == '0) ? ONE : div_in;
  assign accept     = div_valid && !pend_q;
  // >= rather than == so a count left above a freshly shrunk divisor still wraps.
  assign wrap       = en && (count_q >= (div_act_q - ONE));
  assign high_phase = count_q < (div_act_q >> 1);

  // Next-state: shadow/handshake, then counter and output decode in priority order.
  always_comb begin
    count_d     = count_q;
    div_act_d   = div_act_q;
    shadow_d    = shadow_q;
    pend_d      = pend_q;
    clock_out_d = clock_out_q;
    tick_d      = 1'b0;

    // Accept only happens with pend_q=0, so it never collides with the switch below.
    if (accept) begin
      shadow_d = div_in_san;
      pend_d   = 1'b1;
    end

    if (sync_clr) begin
      count_d     = '0;
      clock_out_d = 1'b0;
      if (pend_q) begin
        div_act_d = shadow_q;
        pend_d    = 1'b0;
      end
    end else if (!en) begin
      // Frozen: count and clock_out hold, tick stays low.
    end else if (wrap) begin
      count_d     = '0;
      tick_d      = 1'b1;
      clock_out_d = high_phase;
      if (pend_q) begin
        div_act_d = shadow_q;
        pend_d    = 1'b0;
      end
    end else begin
      count_d     = count_q + ONE;
      clock_out_d = high_phase;
    end
  end

  // State registers; reset restarts the phase and discards any pending divisor.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      count_q     <= '0;
      div_act_q   <= DEF_DIV;
      shadow_q    <= '0;
      pend_q      <= 1'b0;
      clock_out_q <= 1'b0;
      tick_q      <= 1'b0;
    end else begin
      count_q     <= count_d;
      div_act_q   <= div_act_d;
      shadow_q    <= shadow_d;
      pend_q      <= pend_d;
      clock_out_q <= clock_out_d;
      tick_q      <= tick_d;
    end
  end

  assign div_ready = !pend_q;
  assign clock_out = clock_out_q;
  assign tick      = tick_q;
  assign div_act   = div_act_q;
  assign count     = count_q;

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed bench for clk_divider_prog with an 8-bit counter and a reset divisor of 10.
// Each vector is applied for one clock; outputs are sampled 1ns after the edge.
// No DUT-driven waits: every sequence is a fixed number of clocks.
module tb_clk_divider_prog;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         clr;
  logic [W-1:0] din;
  logic         vld;
  logic         rdy;
  logic         clko;
  logic         tick;
  logic [W-1:0] dact;
  logic [W-1:0] cnt;

  int checks   = 0;
  int failures = 0;

  clk_divider_prog #(.WIDTH(W), .DEFAULT_DIV(10)) dut (
    .clock_in  (clk),
    .reset_n   (rst_n),
    .en        (en),
    .sync_clr  (clr),
    .div_in    (din),
    .div_valid (vld),
    .div_ready (rdy),
    .clock_out (clko),
    .tick      (tick),
    .div_act   (dact),
    .count     (cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic         en;
    logic         clr;
    logic         vld;
    logic [W-1:0] din;
    logic         tick;
    logic         clko;
    logic [W-1:0] cnt;
    logic [W-1:0] dact;
    logic         rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic v(input logic i_en, input logic i_clr, input logic i_vld, input int i_din,
                   input logic e_tick, input logic e_clko, input int e_cnt, input int e_dact,
                   input logic e_rdy);
    vec_t r;
    r.en   = i_en;
    r.clr  = i_clr;
    r.vld  = i_vld;
    r.din  = W'(i_din);
    r.tick = e_tick;
    r.clko = e_clko;
    r.cnt  = W'(e_cnt);
    r.dact = W'(e_dact);
    r.rdy  = e_rdy;
    vecs.push_back(r);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0d expected=%0d", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input int idx, input logic e_tick, input logic e_clko,
                         input int e_cnt, input int e_dact, input logic e_rdy);
    chk("tick",      idx, int'(tick), int'(e_tick));
    chk("clock_out", idx, int'(clko), int'(e_clko));
    chk("count",     idx, int'(cnt),  e_cnt);
    chk("div_act",   idx, int'(dact), e_dact);
    chk("div_ready", idx, int'(rdy),  int'(e_rdy));
  endtask

  initial begin
    // en clr vld din | tick clko cnt dact rdy
    // Default divisor 10: 5 high / 5 low, first tick on the 10th enabled edge.
    v(1,0,0,0, 0,1,1,10,1); v(1,0,0,0, 0,1,2,10,1); v(1,0,0,0, 0,1,3,10,1);
    v(1,0,0,0, 0,1,4,10,1); v(1,0,0,0, 0,1,5,10,1); v(1,0,0,0, 0,0,6,10,1);
    v(1,0,0,0, 0,0,7,10,1); v(1,0,0,0, 0,0,8,10,1); v(1,0,0,0, 0,0,9,10,1);
    v(1,0,0,0, 1,0,0,10,1);
    v(1,0,0,0, 0,1,1,10,1); v(1,0,0,0, 0,1,2,10,1); v(1,0,0,0, 0,1,3,10,1);
    // Load 4 at count 3; a second request (7) is stalled while pending.
    v(1,0,1,4, 0,1,4,10,0); v(1,0,1,7, 0,1,5,10,0); v(1,0,1,7, 0,0,6,10,0);
    v(1,0,1,7, 0,0,7,10,0); v(1,0,1,7, 0,0,8,10,0); v(1,0,1,7, 0,0,9,10,0);
    v(1,0,0,0, 1,0,0,4,1);
    // Divisor 4: 2 high / 2 low.
    v(1,0,0,0, 0,1,1,4,1); v(1,0,0,0, 0,1,2,4,1); v(1,0,0,0, 0,0,3,4,1);
    v(1,0,0,0, 1,0,0,4,1);
    // Load 0 -> stored as 1: tick every cycle, clock_out 0.
    v(1,0,1,0, 0,1,1,4,0); v(1,0,0,0, 0,1,2,4,0); v(1,0,0,0, 0,0,3,4,0);
    v(1,0,0,0, 1,0,0,1,1); v(1,0,0,0, 1,0,0,1,1);
    // Accept 3 on a wrap cycle: shadow only, applied at the following boundary.
    v(1,0,1,3, 1,0,0,1,0); v(1,0,0,0, 1,0,0,3,1);
    // Divisor 3: 1 high / 2 low.
    v(1,0,0,0, 0,1,1,3,1); v(1,0,0,0, 0,0,2,3,1); v(1,0,0,0, 1,0,0,3,1);
    // Back to 10.
    v(1,0,1,10, 0,1,1,3,0); v(1,0,0,0, 0,0,2,3,0); v(1,0,0,0, 1,0,0,10,1);
    v(1,0,0,0, 0,1,1,10,1); v(1,0,0,0, 0,1,2,10,1); v(1,0,0,0, 0,1,3,10,1);
    v(1,0,0,0, 0,1,4,10,1); v(1,0,0,0, 0,1,5,10,1); v(1,0,0,0, 0,0,6,10,1);
    // en low at count 6 for 7 cycles: everything holds.
    for (int i = 0; i < 7; i++) v(0,0,0,0, 0,0,6,10,1);
    // Resume: tick on the 4th enabled edge.
    v(1,0,0,0, 0,0,7,10,1); v(1,0,0,0, 0,0,8,10,1); v(1,0,0,0, 0,0,9,10,1);
    v(1,0,0,0, 1,0,0,10,1);
    // sync_clr with 6 pending: immediate switch, restart at 0.
    v(1,0,1,6, 0,1,1,10,0); v(1,0,0,0, 0,1,2,10,0); v(1,1,0,0, 0,0,0,6,1);
    v(1,0,0,0, 0,1,1,6,1); v(1,0,0,0, 0,1,2,6,1); v(1,0,0,0, 0,1,3,6,1);
    v(1,0,0,0, 0,0,4,6,1); v(1,0,0,0, 0,0,5,6,1);
    // sync_clr on the wrap cycle suppresses the tick.
    v(1,1,0,0, 0,0,0,6,1); v(1,0,0,0, 0,1,1,6,1);
    // Leave 4 pending for the reset sequence.
    v(1,0,1,4, 0,1,2,6,0);

    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    vld   = 1'b0;
    din   = '0;
    #22;
    chk_all(-1, 1'b0, 1'b0, 0, 10, 1'b1);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      en  = vecs[i].en;
      clr = vecs[i].clr;
      vld = vecs[i].vld;
      din = vecs[i].din;
      step();
      chk_all(i, vecs[i].tick, vecs[i].clko, int'(vecs[i].cnt), int'(vecs[i].dact), vecs[i].rdy);
    end

    // Asynchronous reset mid-cycle with 4 pending.
    en  = 1'b1;
    clr = 1'b0;
    vld = 1'b0;
    din = '0;
    #3;
    rst_n = 1'b0;
    #1;
    chk_all(1000, 1'b0, 1'b0, 0, 10, 1'b1);
    #2;
    rst_n = 1'b1;
    // The pending 4 was dropped: a full 10-cycle period follows.
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_tick", 1001 + i, int'(tick), (i == 9) ? 1 : 0);
      chk("rst_div_act", 1001 + i, int'(dact), 10);
      chk("rst_count", 1001 + i, int'(cnt), (i + 1) % 10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
